// File: rtl/soc_pkg.sv
// rtl/soc_pkg.sv - shared types and constants for the data-memory arbiter
package soc_pkg;

  localparam int DMEM_DW = 32;

  typedef enum logic [0:0] {
    S_CORE,
    S_DBG_BURST
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE,
    CORE,
    DBG
  } rd_owner_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - core, debug and dmem signal bundle for dmem_arbiter
interface dmem_arbiter_if #(
  parameter int AW = 10
);
  import soc_pkg::*;

  logic               core_req;
  logic               core_we;
  logic [AW-1:0]      core_addr;
  logic [DMEM_DW-1:0] core_wdata;
  logic [3:0]         core_wmask;
  logic               core_gnt;
  logic               core_rvalid;
  logic [DMEM_DW-1:0] core_rdata;
  logic               core_stall;

  logic               dbg_req;
  logic               dbg_we;
  logic [AW-1:0]      dbg_addr;
  logic [DMEM_DW-1:0] dbg_wdata;
  logic [3:0]         dbg_wmask;
  logic               dbg_last;
  logic               dbg_gnt;
  logic               dbg_rvalid;
  logic [DMEM_DW-1:0] dbg_rdata;

  logic               mem_en;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DMEM_DW-1:0] mem_wdata;
  logic [3:0]         mem_wmask;
  logic [DMEM_DW-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  core_req, core_we, core_addr, core_wdata, core_wmask,
    output core_gnt, core_rvalid, core_rdata, core_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_wmask, dbg_last,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_rdata
  );

  // Requester / memory side
  modport master (
    output core_req, core_we, core_addr, core_wdata, core_wmask,
    input  core_gnt, core_rvalid, core_rdata, core_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_wmask, dbg_last,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/debug arbiter for single-port dmem; DMEM_ARB_STATS_EN adds grant/conflict counters
module dmem_arbiter
  import soc_pkg::*;
#(
  parameter int AW           = 10,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 8
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]   core_grant_cnt,
  output logic [31:0]   dbg_grant_cnt,
  output logic [31:0]   conflict_cnt
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [BW-1:0] BEAT_MAX   = BW'(MAX_BURST);

  arb_state_t         state, state_nxt;
  rd_owner_t          rd_owner, rd_owner_nxt;
  logic [SW-1:0]      starve_cnt, starve_nxt;
  logic [BW-1:0]      beat_cnt, beat_nxt;
  logic               core_gnt, dbg_gnt;
  logic [AW-1:0]      mem_addr_c;
  logic [DMEM_DW-1:0] core_rdata_q, dbg_rdata_q;

  // Grant selection, burst/starvation bookkeeping; nothing is granted while reset is asserted
  always_comb begin
    core_gnt     = 1'b0;
    dbg_gnt      = 1'b0;
    state_nxt    = state;
    starve_nxt   = starve_cnt;
    beat_nxt     = beat_cnt;
    rd_owner_nxt = NONE;
    if (reset) begin
      case (state)
        S_CORE: begin
          if (bus.dbg_req && (!bus.core_req || starve_cnt == STARVE_MAX)) dbg_gnt = 1'b1;
          else core_gnt = bus.core_req;
        end
        default: begin
          // Core only breaks into a burst at the beat cap or once dbg stops asking
          if (bus.core_req && (beat_cnt == BEAT_MAX || !bus.dbg_req)) core_gnt = 1'b1;
          else dbg_gnt = bus.dbg_req;
        end
      endcase

      if (dbg_gnt) begin
        if (bus.dbg_last) begin
          state_nxt = S_CORE;
          beat_nxt  = '0;
        end else begin
          state_nxt = S_DBG_BURST;
          beat_nxt  = (beat_cnt == BEAT_MAX) ? beat_cnt : beat_cnt + 1'b1;
        end
      end else if (state == S_DBG_BURST) begin
        state_nxt = S_CORE;
        beat_nxt  = '0;
      end

      if (dbg_gnt || !bus.dbg_req) starve_nxt = '0;
      else if (core_gnt && starve_cnt != STARVE_MAX) starve_nxt = starve_cnt + 1'b1;

      if (core_gnt && !bus.core_we) rd_owner_nxt = CORE;
      else if (dbg_gnt && !bus.dbg_we) rd_owner_nxt = DBG;
    end
  end

  // Memory port mux: driven from whichever requester holds the grant, zero otherwise
  always_comb begin
    bus.mem_we    = 1'b0;
    mem_addr_c    = '0;
    bus.mem_wdata = '0;
    bus.mem_wmask = '0;
    if (core_gnt) begin
      bus.mem_we    = bus.core_we;
      mem_addr_c    = bus.core_addr;
      bus.mem_wdata = bus.core_wdata;
      bus.mem_wmask = bus.core_wmask;
    end else if (dbg_gnt) begin
      bus.mem_we    = bus.dbg_we;
      mem_addr_c    = bus.dbg_addr;
      bus.mem_wdata = bus.dbg_wdata;
      bus.mem_wmask = bus.dbg_wmask;
    end
  end

  assign bus.mem_addr    = mem_addr_c;
  assign bus.mem_en      = core_gnt | dbg_gnt;
  assign bus.core_gnt    = core_gnt;
  assign bus.dbg_gnt     = dbg_gnt;
  assign bus.core_stall  = reset & bus.core_req & ~core_gnt;
  assign bus.core_rvalid = (rd_owner == CORE);
  assign bus.dbg_rvalid  = (rd_owner == DBG);
  assign bus.core_rdata  = (rd_owner == CORE) ? bus.mem_rdata : core_rdata_q;
  assign bus.dbg_rdata   = (rd_owner == DBG)  ? bus.mem_rdata : dbg_rdata_q;

  // State, counters, read owner and held read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_CORE;
      starve_cnt   <= '0;
      beat_cnt     <= '0;
      rd_owner     <= NONE;
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      beat_cnt   <= beat_nxt;
      rd_owner   <= rd_owner_nxt;
      if (rd_owner == CORE) core_rdata_q <= bus.mem_rdata;
      if (rd_owner == DBG)  dbg_rdata_q  <= bus.mem_rdata;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  // Free-running wrap-around grant and conflict counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_grant_cnt <= '0;
      dbg_grant_cnt  <= '0;
      conflict_cnt   <= '0;
    end else begin
      if (core_gnt) core_grant_cnt <= core_grant_cnt + 32'd1;
      if (dbg_gnt)  dbg_grant_cnt  <= dbg_grant_cnt + 32'd1;
      if (bus.core_req && bus.dbg_req) conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;
  import soc_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem     [0:1023];
  logic [31:0] exp_mem [0:1023];
  logic [31:0] core_q[$];
  logic [31:0] dbg_q[$];

  dmem_arbiter_if #(.AW(10)) bus ();

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] core_grant_cnt, dbg_grant_cnt, conflict_cnt;
`endif

  dmem_arbiter #(.AW(10), .STARVE_LIMIT(4), .MAX_BURST(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DMEM_ARB_STATS_EN
    ,
    .core_grant_cnt (core_grant_cnt),
    .dbg_grant_cnt  (dbg_grant_cnt),
    .conflict_cnt   (conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic exp_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
    for (int k = 0; k < 4; k++)
      if (m[k]) exp_mem[a][8*k +: 8] = d[8*k +: 8];
  endtask

  // Single-port dmem model with one-cycle read latency
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int k = 0; k < 4; k++)
          if (bus.mem_wmask[k]) mem[bus.mem_addr][8*k +: 8] <= bus.mem_wdata[8*k +: 8];
      end else begin
        bus.mem_rdata <= mem[bus.mem_addr];
      end
    end
  end

  // Read-return monitor: each queued read must come back on the very next cycle
  always @(negedge clk) begin
    if (core_q.size() != 0 || bus.core_rvalid) begin
      check("core_rvalid", {31'b0, bus.core_rvalid}, {31'b0, core_q.size() != 0});
      if (core_q.size() != 0 && bus.core_rvalid) check("core_rdata", bus.core_rdata, core_q.pop_front());
      else if (core_q.size() != 0) void'(core_q.pop_front());
    end
    if (dbg_q.size() != 0 || bus.dbg_rvalid) begin
      check("dbg_rvalid", {31'b0, bus.dbg_rvalid}, {31'b0, dbg_q.size() != 0});
      if (dbg_q.size() != 0 && bus.dbg_rvalid) check("dbg_rdata", bus.dbg_rdata, dbg_q.pop_front());
      else if (dbg_q.size() != 0) void'(dbg_q.pop_front());
    end
  end

  // Called just after a negedge with inputs set; checks grants/routing and feeds the scoreboard
  task automatic step(input logic ec, input logic ed, input string tag);
    #1;
    check({tag, "_core_gnt"}, {31'b0, bus.core_gnt}, {31'b0, ec});
    check({tag, "_dbg_gnt"}, {31'b0, bus.dbg_gnt}, {31'b0, ed});
    check({tag, "_stall"}, {31'b0, bus.core_stall}, {31'b0, bus.core_req & ~ec});
    check({tag, "_mem_en"}, {31'b0, bus.mem_en}, {31'b0, ec | ed});
    if (ec) begin
      check({tag, "_mem_addr"}, {22'b0, bus.mem_addr}, {22'b0, bus.core_addr});
      check({tag, "_mem_we"}, {31'b0, bus.mem_we}, {31'b0, bus.core_we});
      if (bus.core_we) exp_write(bus.core_addr, bus.core_wdata, bus.core_wmask);
      else core_q.push_back(exp_mem[bus.core_addr]);
    end else if (ed) begin
      check({tag, "_mem_addr"}, {22'b0, bus.mem_addr}, {22'b0, bus.dbg_addr});
      check({tag, "_mem_we"}, {31'b0, bus.mem_we}, {31'b0, bus.dbg_we});
      if (bus.dbg_we) exp_write(bus.dbg_addr, bus.dbg_wdata, bus.dbg_wmask);
      else dbg_q.push_back(exp_mem[bus.dbg_addr]);
    end
    @(negedge clk);
  endtask

  initial begin
    int b;
    logic core_done;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'hC0DE_0000 + i * 32'h0001_0003;
      exp_mem[i] = 32'hC0DE_0000 + i * 32'h0001_0003;
    end
    mem[5]     = 32'h1234_ABCD;
    exp_mem[5] = 32'h1234_ABCD;

    reset = 1'b0;
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = '0; bus.core_wdata = '0; bus.core_wmask = '0;
    bus.dbg_req = 1'b1;  bus.dbg_we = 1'b0;  bus.dbg_addr = '0;  bus.dbg_wdata = '0;  bus.dbg_wmask = '0;
    bus.dbg_last = 1'b0;

    // Reset state with both requests asserted
    @(negedge clk);
    #1;
    check("rst_core_gnt", {31'b0, bus.core_gnt}, 32'd0);
    check("rst_dbg_gnt", {31'b0, bus.dbg_gnt}, 32'd0);
    check("rst_mem_en", {31'b0, bus.mem_en}, 32'd0);
    check("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
    check("rst_stall", {31'b0, bus.core_stall}, 32'd0);
    check("rst_core_rvalid", {31'b0, bus.core_rvalid}, 32'd0);
    check("rst_dbg_rvalid", {31'b0, bus.dbg_rvalid}, 32'd0);
    check("rst_core_rdata", bus.core_rdata, 32'd0);
    check("rst_dbg_rdata", bus.dbg_rdata, 32'd0);
    check("rst_state", 32'(dut.state), 32'(S_CORE));
    bus.core_req = 1'b0; bus.dbg_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 1'b0, "idle");

    // 1: core-only read of 0x005
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 10'h005;
    step(1'b1, 1'b0, "t1");
    bus.core_req = 1'b0;
    step(1'b0, 1'b0, "t1_idle");

    // 2: contention, starvation guard after four core grants
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
`ifdef DMEM_ARB_STATS_EN
    check("stats_rst_core", core_grant_cnt, 32'd0);
    check("stats_rst_conflict", conflict_cnt, 32'd0);
`endif
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 10'h005; bus.dbg_last = 1'b1;
    bus.core_req = 1'b1; bus.core_we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.core_addr = 10'h020 + 10'(i);
      step(i != 4, i == 4, "t2");
    end
    bus.core_req = 1'b0; bus.dbg_req = 1'b0; bus.dbg_last = 1'b0;
    step(1'b0, 1'b0, "t2_idle");
`ifdef DMEM_ARB_STATS_EN
    check("stats_core_grant_cnt", core_grant_cnt, 32'd5);
    check("stats_dbg_grant_cnt", dbg_grant_cnt, 32'd1);
    check("stats_conflict_cnt", conflict_cnt, 32'd6);
`endif

    // 3: three-beat debug write burst, then core reads one back
    for (int i = 0; i < 3; i++) begin
      bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 10'h010 + 10'(i);
      bus.dbg_wdata = 32'hA5A5_0000 | i; bus.dbg_wmask = (i == 1) ? 4'b0011 : 4'hF;
      bus.dbg_last = (i == 2);
      step(1'b0, 1'b1, "t3");
    end
    bus.dbg_req = 1'b0; bus.dbg_last = 1'b0;
    check("t3_state", 32'(dut.state), 32'(S_CORE));
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 10'h011;
    step(1'b1, 1'b0, "t3_rd");
    bus.core_req = 1'b0;
    step(1'b0, 1'b0, "t3_idle");

    // 4: 20-beat burst, core raised at beat 2 gets in after beat 8
    b = 1; core_done = 1'b0;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_wmask = 4'hF;
    bus.core_we = 1'b0; bus.core_addr = 10'h012;
    for (int c = 0; c < 21; c++) begin
      bus.dbg_addr  = 10'h040 + 10'(b - 1);
      bus.dbg_wdata = 32'hD000_0000 | b;
      bus.dbg_last  = (b == 20);
      if (b >= 2 && !core_done) bus.core_req = 1'b1;
      step(c == 8, c != 8, "t4");
      if (c == 8) begin
        core_done = 1'b1;
        bus.core_req = 1'b0;
      end else begin
        b++;
      end
    end
    bus.dbg_req = 1'b0; bus.dbg_last = 1'b0;
    check("t4_state", 32'(dut.state), 32'(S_CORE));
    bus.core_req = 1'b1; bus.core_addr = 10'h048;
    step(1'b1, 1'b0, "t4_rd");
    bus.core_req = 1'b0;
    step(1'b0, 1'b0, "t4_idle");

    // 5: reset while a debug read is in flight
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 10'h011;
    #1;
    check("t5_dbg_gnt", {31'b0, bus.dbg_gnt}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("t5_rst_dbg_gnt", {31'b0, bus.dbg_gnt}, 32'd0);
    check("t5_rst_mem_en", {31'b0, bus.mem_en}, 32'd0);
    check("t5_rst_core_rdata", bus.core_rdata, 32'd0);
    check("t5_rst_state", 32'(dut.state), 32'(S_CORE));
    @(negedge clk);
    check("t5_dbg_rvalid", {31'b0, bus.dbg_rvalid}, 32'd0);
    check("t5_dbg_rdata", bus.dbg_rdata, 32'd0);
    bus.dbg_req = 1'b0;
    reset = 1'b1;
    #1;
    check("t5_state", 32'(dut.state), 32'(S_CORE));
    check("t5_dbg_rvalid_rel", {31'b0, bus.dbg_rvalid}, 32'd0);
    @(negedge clk);

    check("core_q_drained", core_q.size(), 32'd0);
    check("dbg_q_drained", dbg_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
